// File: rtl/tb_clock_reset_gen_pkg.sv
// tb_clkrst_pkg: shared sizing helpers and parameter legality checks for the clock/reset generator
package tb_clkrst_pkg;

    function automatic int hi_cycles(input int period);
        return (period + 1) / 2;
    endfunction

    function automatic int rcnt_width(input int delay);
        return $clog2(delay + 1);
    endfunction

    function automatic int pcnt_width(input int period);
        return $clog2(period);
    endfunction

    function automatic bit period_ok(input int period);
        return period >= 2;
    endfunction

    function automatic bit delay_ok(input int delay);
        return delay >= 1;
    endfunction

endpackage

// File: rtl/tb_clock_reset_gen_if.sv
// tb_clock_reset_gen_if: restart request in, derived clock/strobe and reset pair out
interface tb_clock_reset_gen_if;

    logic iRESTART;
    logic oCLK;
    logic oCLK_STB;
    logic oRST;
    logic oRSTb;

    modport master (input iRESTART, output oCLK, output oCLK_STB, output oRST, output oRSTb);
    modport slave (output iRESTART, input oCLK, input oCLK_STB, input oRST, input oRSTb);

endinterface

// File: rtl/tb_clock_reset_gen_clk_div.sv
// clk_div: free-running divider with registered clock and phase-zero strobe
module clk_div
    import tb_clkrst_pkg::*;
#(
    parameter int PERIOD = 2
) (
    input  logic iCLK,
    input  logic iRST,
    output logic oCLK,
    output logic oCLK_STB
);

    localparam int PW = pcnt_width(PERIOD);
    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] HI = PW'(hi_cycles(PERIOD));

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_n;

    always_comb pcnt_n = (pcnt == LAST) ? '0 : pcnt + 1'b1;

    // Outputs are decoded from the next phase so they line up with pcnt after the edge
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pcnt     <= LAST;
            oCLK     <= 1'b0;
            oCLK_STB <= 1'b0;
        end else begin
            pcnt     <= pcnt_n;
            oCLK     <= pcnt_n < HI;
            oCLK_STB <= pcnt_n == '0;
        end
    end

endmodule

// File: rtl/tb_clock_reset_gen.sv
// tb_clock_reset_gen: divided clock plus a re-armable power-on reset sequencer
module tb_clock_reset_gen
    import tb_clkrst_pkg::*;
#(
    parameter int PERIOD = 2,
    parameter int DELAY  = 100
) (
    input logic iCLK,
    input logic iRST,
    tb_clock_reset_gen_if.master bus
);

    if (!period_ok(PERIOD)) begin : g_bad_period
        $error("PERIOD must be >= 2");
    end
    if (!delay_ok(DELAY)) begin : g_bad_delay
        $error("DELAY must be >= 1");
    end

    localparam int RW = rcnt_width(DELAY);
    localparam logic [RW-1:0] DMAX = RW'(DELAY);

    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;

    clk_div #(.PERIOD(PERIOD)) u_div (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .oCLK     (bus.oCLK),
        .oCLK_STB (bus.oCLK_STB)
    );

    // A restart always rewinds to zero, so it can only lengthen an active sequence
    always_comb rcnt_n = bus.iRESTART ? '0 : (rcnt == DMAX) ? rcnt : rcnt + 1'b1;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rcnt      <= '0;
            bus.oRST  <= 1'b1;
            bus.oRSTb <= 1'b0;
        end else begin
            rcnt      <= rcnt_n;
            bus.oRST  <= rcnt_n != DMAX;
            bus.oRSTb <= rcnt_n == DMAX;
        end
    end

endmodule

// File: tb/tb_tb_clock_reset_gen.sv
// tb_tb_clock_reset_gen: scoreboard bench for even (4) and odd (5) period generators with DELAY 10
module tb_tb_clock_reset_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int k = 0;
    int a = 0;
    int edge_no = 0;

    typedef struct packed {
        logic clk4;
        logic stb4;
        logic clk5;
        logic stb5;
        logic orst;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    tb_clock_reset_gen_if bus4 ();
    tb_clock_reset_gen_if bus5 ();

    tb_clock_reset_gen #(.PERIOD(4), .DELAY(10)) dut4 (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus4)
    );

    tb_clock_reset_gen #(.PERIOD(5), .DELAY(10)) dut5 (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus5)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %b expected %b", tag, edge_no, got, exp);
        end
    endtask

    // Model: k counts edges since release, a is the edge where the reset count was last anchored
    task automatic step(input logic r, input logic rs);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus4.iRESTART = rs;
        bus5.iRESTART = rs;
        e = '0;
        if (r) begin
            k = 0;
            a = 0;
            e.orst = 1'b1;
        end else begin
            k++;
            if (rs) a = k;
            e.clk4 = ((k - 1) % 4) < 2;
            e.stb4 = ((k - 1) % 4) == 0;
            e.clk5 = ((k - 1) % 5) < 3;
            e.stb5 = ((k - 1) % 5) == 0;
            e.orst = (k - a) < 10;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        edge_no++;
        e = q.pop_front();
        check("clk4", bus4.oCLK, e.clk4);
        check("stb4", bus4.oCLK_STB, e.stb4);
        check("rst4", bus4.oRST, e.orst);
        check("rstb4", bus4.oRSTb, ~e.orst);
        check("clk5", bus5.oCLK, e.clk5);
        check("stb5", bus5.oCLK_STB, e.stb5);
        check("rst5", bus5.oRST, e.orst);
        check("rstb5", bus5.oRSTb, ~e.orst);
    endtask

    initial begin
        bus4.iRESTART = 1'b0;
        bus5.iRESTART = 1'b0;
        repeat (5) step(1'b1, 1'b0);
        for (int i = 1; i <= 35; i++) step(1'b0, i == 20);
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) step(1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
